// File: rtl/bwt_mem_streamer.sv
// Streams LEN_STR-deep byte memory from address 0 onto a valid/ready byte stream.
// Optional running checksum output when BWT_STREAM_CHECKSUM_EN is defined.
module bwt_mem_streamer #(
  parameter int LEN_ADDR = 10,
  parameter int LEN_STR  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_ADDR:0]   length,
  output logic                busy,
  output logic                done,
  output logic                mem_ren,
  output logic [LEN_ADDR-1:0] mem_addr,
  input  logic [7:0]          mem_dout,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
`ifdef BWT_STREAM_CHECKSUM_EN
  ,
  output logic [7:0]          checksum
`endif
);

  localparam logic [LEN_ADDR:0] MAX_LEN = (LEN_ADDR+1)'(LEN_STR);
  localparam logic [LEN_ADDR:0] ONE     = (LEN_ADDR+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  state_t            state;
  logic [LEN_ADDR:0] len_q, rd_cnt, wr_cnt, len_clamp;
  entry_t [1:0]      fifo;
  entry_t            head, arr;
  logic              rptr, wptr, inflight;
  logic [1:0]        occ;
  logic [2:0]        pend;
  logic              accept, pop, fifo_pop, push;

  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
  assign accept    = start && (state == IDLE) && !rst;

  // The in-flight read counts as a buffer slot: when the FIFO is empty the
  // returning byte is presented straight from mem_dout, and only stored if
  // it is not taken this cycle.
  assign arr       = {(wr_cnt == len_q - ONE), mem_dout};
  assign head      = (occ == 2'd0 && inflight) ? arr : fifo[rptr];
  assign out_valid = (occ != 2'd0) || inflight;
  assign out_data  = head.data;
  assign out_last  = out_valid && head.last;

  assign pop      = out_valid && out_ready;
  assign fifo_pop = pop && (occ != 2'd0);
  assign push     = inflight && !(pop && occ == 2'd0);

  assign pend     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign mem_ren  = (state == FETCH) && (pend < 3'd2);
  assign mem_addr = (state == FETCH) ? rd_cnt[LEN_ADDR-1:0] : '0;

  assign busy = (state != IDLE) || accept;
  assign done = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      fifo     <= '0;
      rptr     <= 1'b0;
      wptr     <= 1'b0;
      occ      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_ren;
      if (mem_ren)  rd_cnt <= rd_cnt + ONE;
      if (inflight) wr_cnt <= wr_cnt + ONE;
      if (push) begin
        fifo[wptr] <= arr;
        wptr       <= ~wptr;
      end
      if (fifo_pop) rptr <= ~rptr;
      occ <= occ + {1'b0, push} - {1'b0, fifo_pop};

      unique case (state)
        IDLE: if (accept) begin
          len_q  <= len_clamp;
          rd_cnt <= '0;
          wr_cnt <= '0;
          state  <= (len_clamp == '0) ? FIN : FETCH;
        end
        FETCH: if (mem_ren && (rd_cnt + ONE == len_q)) state <= DRAIN;
        DRAIN: if (pop && out_last) state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BWT_STREAM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) checksum <= '0;
    else if (pop)      checksum <= checksum + out_data;
  end
`endif

endmodule

// File: tb/tb_bwt_mem_streamer.sv
// Directed bench for bwt_mem_streamer: vector table of streams plus reset/restart sequences.
module tb_bwt_mem_streamer;
  localparam int LA = 10;
  localparam int LS = 1024;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, mem_ren;
  logic [LA:0]   length;
  logic [LA-1:0] mem_addr;
  logic [7:0]    mem_dout = 8'h00;
  logic [7:0]    out_data;
  logic          out_valid, out_ready, out_last;
`ifdef BWT_STREAM_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  always #5 clk = ~clk;

  bwt_mem_streamer #(.LEN_ADDR(LA), .LEN_STR(LS)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .busy(busy), .done(done), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
`ifdef BWT_STREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  logic [7:0] mem [LS];
  always @(posedge clk) if (mem_ren) mem_dout <= mem[mem_addr];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // "BANANA$" at 0..6, a distinct pattern above
  function automatic logic [7:0] exp_byte(input int i);
    case (i)
      0: return 8'h42;
      1: return 8'h41;
      2: return 8'h4E;
      3: return 8'h41;
      4: return 8'h4E;
      5: return 8'h41;
      6: return 8'h24;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  typedef struct {
    int len;
    bit toggle;
    int repulse;
    int exp_n;
    int exp_done;
  } vec_t;

  task automatic run_stream(input vec_t v, input string tag);
    int cyc, n, lenq, issued, popped, first, last_hs, done_cyc, done_cnt, last_cnt;
    int bad_data, bad_stall, bad_ren, bad_addr, bad_busy;
    logic pv, pr, pl;
    logic [7:0] pd, sum;
    n = 0; issued = 0; popped = 0; first = -1; last_hs = -1; done_cyc = -1;
    done_cnt = 0; last_cnt = 0; bad_data = 0; bad_stall = 0; bad_ren = 0;
    bad_addr = 0; bad_busy = 0; pv = 0; pr = 0; pl = 0; pd = 0; sum = 0;
    lenq = (v.len > LS) ? LS : v.len;
    @(negedge clk);
    start = 1'b1; length = (LA+1)'(v.len); out_ready = 1'b1;
    #1 check({tag, "_busy_on_start"}, int'(busy), 1);
    @(negedge clk);
    cyc = 1;
    while (cyc < BUDGET) begin
      out_ready = v.toggle ? (((cyc-1) % 4 == 0) || ((cyc-1) % 4 == 3)) : 1'b1;
      start     = (cyc == v.repulse);
      length    = (cyc == v.repulse) ? (LA+1)'(3) : (LA+1)'(v.len);
      #1;
      if (done_cyc >= 0) begin
        check({tag, "_busy_off"}, int'(busy), 0);
        check({tag, "_done_low"}, int'(done), 0);
        break;
      end
      if (mem_ren) begin
        if (issued - popped - int'(out_valid && out_ready) >= 2) bad_ren++;
        if (int'(mem_addr) != issued || issued >= lenq) bad_addr++;
        issued++;
      end
      if (pv && !pr && (!out_valid || out_data != pd || out_last != pl)) bad_stall++;
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        if (out_data != exp_byte(n)) bad_data++;
        if (out_last) last_cnt++;
        if (out_last != (n == lenq - 1)) bad_data++;
        sum = sum + out_data;
        n++; popped++; last_hs = cyc;
      end
      if (done_cyc < 0 && !busy) bad_busy++;
      if (done) begin
        done_cnt++; done_cyc = cyc;
`ifdef BWT_STREAM_CHECKSUM_EN
        check({tag, "_checksum"}, int'(checksum), int'(sum));
`endif
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= BUDGET) check({tag, "_timeout"}, 0, 1);
    check({tag, "_nbytes"}, n, v.exp_n);
    check({tag, "_data"}, bad_data, 0);
    check({tag, "_stall_hold"}, bad_stall, 0);
    check({tag, "_ren_rule"}, bad_ren, 0);
    check({tag, "_addr"}, bad_addr, 0);
    check({tag, "_busy"}, bad_busy, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_last_cnt"}, last_cnt, (lenq > 0) ? 1 : 0);
    if (v.exp_done >= 0) check({tag, "_done_cyc"}, done_cyc, v.exp_done);
    if (lenq > 0) begin
      check({tag, "_first_valid"}, first, 2);
      check({tag, "_done_after_last"}, done_cyc, last_hs + 1);
    end else begin
      check({tag, "_no_valid"}, first, -1);
      check({tag, "_no_reads"}, issued, 0);
    end
  endtask

  vec_t vecs [6];
  vec_t tail;
  int   bad;

  initial begin
    for (int i = 0; i < LS; i++) mem[i] = exp_byte(i);
    vecs[0] = '{7,    1'b0, -1, 7,    9};
    vecs[1] = '{7,    1'b1, -1, 7,    -1};
    vecs[2] = '{0,    1'b0, -1, 0,    1};
    vecs[3] = '{2047, 1'b0, -1, 1024, 1026};
    vecs[4] = '{7,    1'b0, 4,  7,    9};
    vecs[5] = '{1,    1'b0, -1, 1,    3};
    tail    = '{3,    1'b0, -1, 3,    5};

    rst = 1'b1; start = 1'b0; length = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_ren", int'(mem_ren), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_stream(vecs[i], $sformatf("v%0d", i));

    // abort a stalled stream three cycles in
    @(negedge clk);
    start = 1'b1; length = (LA+1)'(7); out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_mem_ren", int'(mem_ren), 0);
    check("abort_mem_addr", int'(mem_addr), 0);
    check("abort_out_data", int'(out_data), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_last", int'(out_last), 0);
    rst = 1'b0; out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done || out_valid || mem_ren || busy) bad++;
    end
    check("abort_quiet", bad, 0);

    run_stream(tail, "after_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
